// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU write-back types: register/data widths and the {rd, data} result record
// carried by the MDU and buffered in the write-port FIFO.
package wb_port_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
      return 32'd1 << rd;
   endfunction
endpackage

// File: rtl/wb_req_fifo.sv
// Small FIFO of pending MDU write-back results; exposes per-slot valid bits and
// destination registers so the arbiter can build the interlock mask.
module wb_req_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  wb_req_t                              req,
   input  logic                                 pop,
   output logic                                 full,
   output logic                                 empty,
   output wb_req_t                              head,
   output logic [DEPTH-1:0]                     ent_vld,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_req_t [DEPTH-1:0] mem;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PTR_W:0]      count;

   // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (pop) begin
            rd_ptr          <= rd_ptr + PTR_W'(1);
            ent_vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr          <= wr_ptr + PTR_W'(1);
            ent_vld[wr_ptr] <= 1'b1;
         end
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= req;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win outright, buffered MDU results
// drain into idle cycles, and a starved FIFO requests a pipeline bubble.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wen,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pend_mask,
   output logic        stall_req
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic                             full, empty, pipe_act, drain, push;
   wb_req_t                          head;
   logic [DEPTH-1:0]                 ent_vld;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
   logic [CNT_W-1:0]                 wait_cnt;

   assign pipe_act = pipe_wen && (pipe_rd != REG_ZERO);
   assign drain    = !rst && !pipe_act && !empty;
   // r0 results are acknowledged to the MDU but never stored.
   assign push     = !rst && mdu_valid && !full && (mdu_rd != REG_ZERO);

   wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .req     ('{rd: mdu_rd, data: mdu_data}),
      .pop     (drain),
      .full    (full),
      .empty   (empty),
      .head    (head),
      .ent_vld (ent_vld),
      .ent_rd  (ent_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  wait_cnt <= '0;
      else if (drain || empty)  wait_cnt <= '0;
      else if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + CNT_W'(1);
   end

   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = REG_ZERO;
      rf_wdata = '0;
      if (!rst) begin
         if (pipe_act) begin
            rf_wen   = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
         end else if (!empty) begin
            rf_wen   = 1'b1;
            rf_waddr = head.rd;
            rf_wdata = head.data;
         end
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_rd[i]);
   end

   assign mdu_ready = !rst && !full;
   assign stall_req = (wait_cnt == LIMIT);
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Sequential arbiter for the single register-file write port, sitting after the write-back mux. It gives the in-order pipeline write (from the write-back stage) absolute priority. It buffers results from the multi-cycle multiply/divide unit (MDU) in a small FIFO and drains them into idle write-port cycles. When a buffered result waits too long, it asks the hazard unit for a pipeline bubble.

## Interface
- DEPTH, 2, MDU result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive non-drain cycles before a bubble is requested; ≥1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_wen  in  1  write-back stage write enable
- pipe_rd  in  5  write-back destination register
- pipe_data  in  32  write-back mux output
- mdu_valid  in  1  MDU result available
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  FIFO can accept; equals !full
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- pend_mask  out  32  bit r set while any FIFO entry targets register r; used by the hazard unit for RAW/WAW interlock
- stall_req  out  1  request one bubble (pipe_wen=0) from the hazard unit

## Operation
- The pipeline write is "active" when pipe_wen=1 and pipe_rd≠0.
- Active pipeline write: rf_wen=1, rf_waddr=pipe_rd, rf_wdata=pipe_data. The FIFO does not drain.
- No active pipeline write and FIFO non-empty: drain the head. rf_wen=1, waddr/wdata come from the head, and the head pops at the clock edge.
- Otherwise rf_wen=0, and rf_waddr/rf_wdata are 0.
- Push occurs when mdu_valid && mdu_ready at the edge.
  - An entry with mdu_rd=0 is accepted but discarded. It is not stored and does not affect pend_mask.
- Push and pop in the same cycle are both allowed when not full. Occupancy is unchanged.
- When full, mdu_ready=0, even if a pop occurs that cycle.
- Entries drain in strict FIFO order.
- Ordering against pipeline writes to the same register is not arbitrated here; the hazard unit uses pend_mask to interlock.
- pend_mask is the OR of one-hot(rd) over valid entries and is combinational from FIFO state.
- Starvation counter wait_cnt, range 0..STARVE_LIMIT, saturating:
  - clears to 0 on a drain cycle or when the FIFO is empty;
  - otherwise increments each cycle.
- stall_req = (wait_cnt == STARVE_LIMIT). It deasserts the cycle after the drain.

## Timing
- Pipeline path is combinational, with zero added latency.
- MDU path: a push at edge N allows an RF write at the earliest in cycle N+1.
- With a continuous active pipeline write and a non-empty FIFO, stall_req rises STARVE_LIMIT cycles after the FIFO becomes non-empty. The drain happens in the bubble cycle.
- Reset (asynchronous) behaviour:
  - FIFO empties and wait_cnt=0.
  - Outputs while rst=1: rf_wen=0, rf_waddr=0, rf_wdata=0, pend_mask=0, stall_req=0, mdu_ready=0.
  - mdu_ready=1 from the first cycle after release.
  - Reset mid-operation discards buffered results. The MDU is reset by the same signal.
- Pointers wrap modulo DEPTH. Occupancy uses a count of width log2(DEPTH)+1.

## Structure
- The shared CPU package holds:
  - REG_ADDR_W=5 and DATA_W=32;
  - a packed wb_req_t {rd, data} used by the FIFO and by the MDU output;
  - constant REG_ZERO=5'd0.
- One sub-module, wb_req_fifo: parameterised DEPTH, storing wb_req_t, with push/pop/full/empty/head and a valid-entry vector feeding pend_mask.
- Arbitration, the starvation counter and the output mux stay in wb_port_arbiter.

## Test plan
- Pipeline write r5=0x1234, FIFO empty:
  - same-cycle rf_wen=1, waddr=5, wdata=0x1234;
  - no push/pop, and stall_req stays 0.
- MDU push r7=0xDEAD while pipe_wen=0:
  - the next cycle writes r7=0xDEAD;
  - pend_mask bit 7 is high for exactly one cycle.
- Push r3, r4 back to back with the pipeline writing continuously:
  - mdu_ready=0 after two entries;
  - stall_req rises 4 cycles after the first push;
  - the bubble drains r3, then a second bubble drains r4, in order.
- MDU push with mdu_rd=0 → accepted, FIFO stays empty, no RF write, pend_mask=0.
- Full FIFO with a simultaneous drain and mdu_valid → no push that cycle; the push is accepted next cycle.
- Assert rst mid-drain with 2 entries → all outputs 0 immediately; after release, FIFO is empty and mdu_ready=1.
